// File: rtl/cache_control.sv
// cache_control
// -----------------------------------------------------------------------------
// Sequencing FSM for a two-way set-associative cache datapath. It classifies each
// CPU request as a hit, clean miss or dirty miss. It then drives the datapath
// strobes and mux selects, and runs the physical-memory writeback/fill handshakes.
//
// Optional feature: define CACHE_PERF_CNT_EN to make the hit/miss/writeback
// performance counters live. Without it the counter ports are tied to zero and
// no counter flops exist.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   mem_read/mem_write  CPU request, held until mem_resp
//   mem_resp            one-cycle completion pulse to the CPU
//   pmem_read/write     physical-memory line read / write request
//   pmem_resp           one-cycle physical-memory completion
//   hit, dirty          datapath tag match / dirty bit of hit way or victim
//   read, write, load   datapath read strobe, write strobe, line-fill strobe
//   pmem_data_mux_sel   constant 0 (victim data path)
//   pmem_addr_mux_sel   0 = CPU address, 1 = victim address
//   cache_data_mux_sel  0 = CPU write data, 1 = pmem fill data
//   hit_count, miss_count, wb_count   32-bit performance counters
// -----------------------------------------------------------------------------
module cache_control #(
    parameter int s_offset = 5,
    parameter int s_index  = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    input  logic        hit,
    input  logic        dirty,
    output logic        read,
    output logic        write,
    output logic        load,
    output logic        pmem_data_mux_sel,
    output logic        pmem_addr_mux_sel,
    output logic        cache_data_mux_sel,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [31:0] wb_count
);

    // Reject geometries that cannot describe a real line/set layout.
    if (s_offset < 2 || s_index < 1) begin : g_bad_geometry
        $error("cache_control: unsupported cache geometry");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        COMPARE   = 2'd1,
        WRITEBACK = 2'd2,
        FILL      = 2'd3
    } state_e;

    state_e state_q, state_d;
    logic   req;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        mem_resp           = 1'b0;
        pmem_read          = 1'b0;
        pmem_write         = 1'b0;
        read               = 1'b0;
        write              = 1'b0;
        load               = 1'b0;
        pmem_data_mux_sel  = 1'b0;
        pmem_addr_mux_sel  = 1'b0;
        cache_data_mux_sel = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                // A simultaneous read and write is served as a read only.
                read  = mem_read;
                write = mem_write & ~mem_read;
                if (!req) begin
                    // Request withdrawn: go quiet without responding.
                    state_d = IDLE;
                end else if (hit) begin
                    mem_resp = 1'b1;
                    state_d  = IDLE;
                end else if (dirty) begin
                    state_d = WRITEBACK;
                end else begin
                    state_d = FILL;
                end
            end
            WRITEBACK: begin
                // Victim address/data stay valid because the CPU address is held.
                pmem_write        = 1'b1;
                pmem_addr_mux_sel = 1'b1;
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read          = 1'b1;
                cache_data_mux_sel = 1'b1;
                if (pmem_resp) begin
                    load    = 1'b1;
                    // Re-check now hits and completes, merging store data.
                    state_d = COMPARE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_PERF_CNT_EN
    logic [31:0] hit_count_q, hit_count_d;
    logic [31:0] miss_count_q, miss_count_d;
    logic [31:0] wb_count_q, wb_count_d;
    // Marks a COMPARE entered straight from IDLE; the post-fill re-check is
    // not a first look and must not count as a hit.
    logic        first_q, first_d;

    always_comb begin
        first_d      = (state_q == IDLE) && req;
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        wb_count_d   = wb_count_q;
        if (state_q == COMPARE && req && hit && first_q) begin
            hit_count_d = hit_count_q + 32'd1;
        end
        if (state_q == COMPARE && req && !hit) begin
            miss_count_d = miss_count_q + 32'd1;
        end
        if (state_q == WRITEBACK && pmem_resp) begin
            wb_count_d = wb_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            first_q      <= 1'b0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
            wb_count_q   <= '0;
        end else begin
            first_q      <= first_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            wb_count_q   <= wb_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;
    assign wb_count   = wb_count_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;

`ifdef CACHE_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read, mem_write, pmem_resp, hit, dirty;
    logic        mem_resp, pmem_read, pmem_write, read, write, load;
    logic        pmem_data_mux_sel, pmem_addr_mux_sel, cache_data_mux_sel;
    logic [31:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    cache_control #(.s_offset(5), .s_index(3)) dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit(hit), .dirty(dirty), .read(read), .write(write), .load(load),
        .pmem_data_mux_sel(pmem_data_mux_sel), .pmem_addr_mux_sel(pmem_addr_mux_sel),
        .cache_data_mux_sel(cache_data_mux_sel),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    // One cycle of the transaction-level expectation: stimulus plus the outputs
    // that must be visible during that cycle.
    typedef struct {
        bit mr, mw, h, d, pr;
        bit [8:0] eo;  // {resp,prd,pwr,rd,wr,ld,pdsel,amux,cmux}
        logic [31:0] eh, em, ew;
    } cyc_t;

    cyc_t q[$];
    logic [31:0] m_hit, m_miss, m_wb;
    int n_checks = 0, n_err = 0;
    int n_prd, n_pwr, n_ld, n_resp, n_rd, n_wr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic add(input bit mr, input bit mw, input bit h, input bit d, input bit pr,
                       input bit resp, input bit prd, input bit pwr, input bit rd,
                       input bit wr, input bit ld, input bit amux, input bit cmux);
        cyc_t c;
        c.mr = mr; c.mw = mw; c.h = h; c.d = d; c.pr = pr;
        c.eo = {resp, prd, pwr, rd, wr, ld, 1'b0, amux, cmux};
        c.eh = m_hit; c.em = m_miss; c.ew = m_wb;
        q.push_back(c);
    endtask

    function automatic bit rb();
        return bit'($urandom_range(0, 1));
    endfunction

    // Expand one CPU request into its expected cycle sequence.
    task automatic gen_txn(input bit r, input bit w, input bit first_hit, input bit dty,
                           input int wlat, input int flat, input int gap, input bit drop);
        bit rd_e, wr_e;
        rd_e = r;
        wr_e = w & ~r;
        for (int i = 0; i < gap; i++) add(0, 0, rb(), rb(), 0, 0,0,0,0,0,0,0,0);
        add(r, w, rb(), rb(), 0, 0,0,0,0,0,0,0,0);            // accepted while idle
        if (drop) begin
            add(0, 0, rb(), rb(), 0, 0,0,0,0,0,0,0,0);        // withdrawn: no response
            return;
        end
        if (first_hit) begin
            add(r, w, 1, rb(), 0, 1,0,0,rd_e,wr_e,0,0,0);
            m_hit++;
            return;
        end
        add(r, w, 0, dty, 0, 0,0,0,rd_e,wr_e,0,0,0);
        m_miss++;
        if (dty) begin
            for (int i = 0; i < wlat; i++)
                add(r, w, rb(), rb(), bit'(i == wlat - 1), 0,0,1,0,0,0,1,0);
            m_wb++;
        end
        for (int i = 0; i < flat; i++)
            add(r, w, rb(), rb(), bit'(i == flat - 1), 0,1,0,0,0,bit'(i == flat - 1),0,1);
        add(r, w, 1, rb(), 0, 1,0,0,rd_e,wr_e,0,0,0);        // re-check hits
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk); #1;
            mem_read = c.mr; mem_write = c.mw; hit = c.h; dirty = c.d; pmem_resp = c.pr;
            @(negedge clk);
            chk("outputs", {23'd0, mem_resp, pmem_read, pmem_write, read, write, load,
                            pmem_data_mux_sel, pmem_addr_mux_sel, cache_data_mux_sel},
                {23'd0, c.eo});
            chk("hit_count",  hit_count,  CNT_ON ? c.eh : 32'd0);
            chk("miss_count", miss_count, CNT_ON ? c.em : 32'd0);
            chk("wb_count",   wb_count,   CNT_ON ? c.ew : 32'd0);
            n_prd += int'(pmem_read); n_pwr += int'(pmem_write); n_ld += int'(load);
            n_resp += int'(mem_resp); n_rd += int'(read); n_wr += int'(write);
        end
    endtask

    task automatic clr_tally();
        n_prd = 0; n_pwr = 0; n_ld = 0; n_resp = 0; n_rd = 0; n_wr = 0;
    endtask

    initial begin
        int guard;
        rst = 1'b1; mem_read = 0; mem_write = 0; hit = 0; dirty = 0; pmem_resp = 0;
        m_hit = 0; m_miss = 0; m_wb = 0;
        clr_tally();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {23'd0, mem_resp, pmem_read, pmem_write, read, write, load,
                              pmem_data_mux_sel, pmem_addr_mux_sel, cache_data_mux_sel}, 32'd0);
        chk("reset_hit_count", hit_count, 32'd0);
        chk("reset_wb_count", wb_count, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Read hit: response one cycle after the request is seen.
        clr_tally();
        gen_txn(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,0,0,0,0,0,0,0);
        run_q();
        chk("hit_resp_count", n_resp, 1);
        chk("hit_pmem_quiet", n_prd + n_pwr, 0);
        chk("hit_count_after_hit", hit_count, CNT_ON ? 32'd1 : 32'd0);

        // Clean read miss, fill latency 5.
        clr_tally();
        gen_txn(1, 0, 0, 0, 0, 5, 1, 0);
        add(0, 0, 0, 0, 0, 0,0,0,0,0,0,0,0);
        run_q();
        chk("clean_prd_cycles", n_prd, 5);
        chk("clean_load_cycles", n_ld, 1);
        chk("clean_resp_count", n_resp, 1);
        chk("clean_miss_count", miss_count, CNT_ON ? 32'd1 : 32'd0);

        // Dirty write miss: writeback 3 cycles, fill 2 cycles.
        clr_tally();
        gen_txn(0, 1, 0, 1, 3, 2, 0, 0);
        add(0, 0, 0, 0, 0, 0,0,0,0,0,0,0,0);
        run_q();
        chk("dirty_pwr_cycles", n_pwr, 3);
        chk("dirty_write_strobes", n_wr, 2);
        chk("dirty_wb_count", wb_count, CNT_ON ? 32'd1 : 32'd0);

        // Read and write together on a hit: read only, single response.
        clr_tally();
        gen_txn(1, 1, 1, 0, 0, 0, 0, 0);
        run_q();
        chk("rw_read_strobes", n_rd, 1);
        chk("rw_write_strobes", n_wr, 0);
        chk("rw_resp_count", n_resp, 1);

        // Randomized traffic.
        for (int t = 0; t < 200; t++) begin
            bit r, w;
            r = rb();
            w = r ? rb() : 1'b1;
            gen_txn(r, w, bit'($urandom_range(0, 2) == 0), rb(),
                    $urandom_range(1, 6), $urandom_range(1, 6),
                    $urandom_range(0, 2), bit'($urandom_range(0, 9) == 0));
            run_q();
        end
        add(0, 0, 0, 0, 0, 0,0,0,0,0,0,0,0);
        run_q();

        // Reset in the middle of a fill.
        @(posedge clk); #1;
        mem_read = 1; mem_write = 0; hit = 0; dirty = 0; pmem_resp = 0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!pmem_read && guard < 10);
        chk("fill_reached", {31'd0, pmem_read}, 32'd1);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_fill_outputs", {23'd0, mem_resp, pmem_read, pmem_write, read, write, load,
                                 pmem_data_mux_sel, pmem_addr_mux_sel, cache_data_mux_sel}, 32'd0);
        chk("rst_fill_hit_count", hit_count, 32'd0);
        chk("rst_fill_miss_count", miss_count, 32'd0);
        chk("rst_fill_wb_count", wb_count, 32'd0);
        mem_read = 0;
        rst = 1'b0;
        m_hit = 0; m_miss = 0; m_wb = 0;

        // Ten hits after the reset.
        for (int t = 0; t < 10; t++) gen_txn(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,0,0,0,0,0,0,0);
        run_q();
        chk("ten_hits", hit_count, CNT_ON ? 32'd10 : 32'd0);

`ifdef CACHE_PERF_CNT_EN
        // Wrap of the hit counter.
        @(negedge clk);
        force dut.hit_count_q = 32'hFFFF_FFFF;
        #1 release dut.hit_count_q;
        m_hit = 32'hFFFF_FFFF;
        gen_txn(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0,0,0,0,0,0,0,0);
        run_q();
        chk("hit_wrap", hit_count, 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
